// File: rtl/inv_key_expand_128.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inv_key_expand_128                                            |
// | Purpose  : Walks the AES-128 key schedule backwards, starting from the    |
// |            round-10 key and emitting round keys 10 down to 0 through a    |
// |            valid/ready output handshake, one key per accepted transfer.   |
// | Ports    : clk, rst (async, active high)                                  |
// |            start, key_in[127:0]       - begin a walk from round key 10    |
// |            busy                       - walk in progress                  |
// |            round_key[127:0], round_idx[3:0], out_valid, out_last,         |
// |            out_ready                  - key stream handshake              |
// |            done                       - one-cycle pulse after key 0 taken |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module inv_key_expand_128 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Forward AES S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] bit_base;
    // Entry b sits (255-b) bytes up from bit 0; 255-b == ~b for 8 bits.
    bit_base = {~b, 3'b000};
    return c_SBOX[bit_base +: 8];
  endfunction

  // Round constant that was used when key i was derived from key i-1.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   round_key_q, round_key_d;
  logic [3:0]     round_idx_q, round_idx_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic           done_q, done_d;

  // Reverse step: recover key i-1 from key i held in the register.
  logic [31:0]    w_w0, w_w1, w_w2, w_w3;
  logic [31:0]    w_n0, w_n1, w_n2, w_n3;
  logic [31:0]    w_g;
  logic [7:0]     w_sub [4];
  logic [127:0]   w_prev_key;
  logic           w_xfer;

  assign w_w0 = round_key_q[127:96];
  assign w_w1 = round_key_q[95:64];
  assign w_w2 = round_key_q[63:32];
  assign w_w3 = round_key_q[31:0];

  assign w_n3 = w_w3 ^ w_w2;
  assign w_n2 = w_w2 ^ w_w1;
  assign w_n1 = w_w1 ^ w_w0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign w_sub[gi] = sbox(w_n3[8*gi +: 8]);
    end
  endgenerate

  // w_sub[3..0] = S(a), S(b), S(c), S(d): RotWord then SubWord, then Rcon.
  assign w_g        = {w_sub[2] ^ rcon(round_idx_q), w_sub[1], w_sub[0], w_sub[3]};
  assign w_n0       = w_w0 ^ w_g;
  assign w_prev_key = {w_n0, w_n1, w_n2, w_n3};

  assign w_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          round_key_d = key_in;
          round_idx_d = 4'd10;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (w_xfer) begin
          if (round_idx_q == 4'd0) begin
            // Key 0 stays visible on round_key until the next walk.
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            round_key_d = w_prev_key;
            round_idx_d = round_idx_q - 4'd1;
            out_last_d  = (round_idx_q == 4'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == EMIT);
  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule
`default_nettype wire
